// File: rtl/ifm_row_buffer_pkg.sv
// Shared widths and FSM encoding for the IFM three-row line buffer.
package ifm_row_buffer_pkg;

  localparam int unsigned IFM_DW    = 32;
  localparam int unsigned MAX_WIDTH = 256;
  localparam int unsigned W_SIZE    = 10;
  localparam int unsigned BANK_AW   = 8;
  localparam int unsigned NUM_SLOTS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [W_SIZE-1:0] row_t;
  typedef logic [1:0]        slot_t;

endpackage

// File: rtl/ifm_row_bank.sv
// One row slot: simple dual-port RAM with a registered, enable-held read port.
module ifm_row_bank
  import ifm_row_buffer_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               we_i,
  input  logic [BANK_AW-1:0] waddr_i,
  input  logic [IFM_DW-1:0]  wdata_i,
  input  logic               re_i,
  input  logic [BANK_AW-1:0] raddr_i,
  output logic [IFM_DW-1:0]  rdata_o
);

  logic [IFM_DW-1:0] mem_q [MAX_WIDTH];
  logic [IFM_DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register resets so the window taps come up as zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ifm_row_buffer.sv
// Three-slot IFM row ring: fetches requested rows from an upstream stream and
// serves a zero-padded 3-row vertical window one cycle after the read strobe.
module ifm_row_buffer
  import ifm_row_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_frame_start,
  input  logic [W_SIZE-1:0] q_width,
  input  logic              i_req_load,
  input  logic [W_SIZE-1:0] i_req_row,
  output logic              o_ld_req,
  output logic [W_SIZE-1:0] o_ld_row,
  input  logic              i_ld_valid,
  input  logic [IFM_DW-1:0] i_ld_data,
  output logic              o_ld_ready,
  output logic              o_buf_done,
  output logic              o_busy,
  output logic              o_err_overflow,
  input  logic              i_rd_en,
  input  logic [W_SIZE-1:0] i_row,
  input  logic [W_SIZE-1:0] i_col,
  input  logic              i_is_first_row,
  input  logic              i_is_last_row,
  output logic [IFM_DW-1:0] o_data0,
  output logic [IFM_DW-1:0] o_data1,
  output logic [IFM_DW-1:0] o_data2,
  output logic              o_rd_miss
);

  state_e                 state_q, state_d;
  slot_t                  wp_q, wp_d;
  row_t                   cnt_q, cnt_d;
  row_t                   row_q, row_d;
  logic                   pend_v_q, pend_v_d;
  row_t                   pend_row_q, pend_row_d;
  logic [NUM_SLOTS-1:0]   valid_q, valid_d;
  row_t                   tag_q [NUM_SLOTS];
  row_t                   tag_d [NUM_SLOTS];
  logic                   ovf_q, ovf_d;
  logic                   ld_req_q, ld_req_d;
  logic                   done_q, done_d;
  logic                   wr_en_c;

  // Fill controller: request arbitration, slot invalidation and completion.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    pend_v_d   = pend_v_q;
    pend_row_d = pend_row_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    ovf_d      = ovf_q;
    ld_req_d   = 1'b0;
    done_d     = 1'b0;
    wr_en_c    = 1'b0;

    if (i_frame_start) begin
      state_d  = ST_IDLE;
      wp_d     = '0;
      cnt_d    = '0;
      pend_v_d = 1'b0;
      valid_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (state_q != ST_IDLE && i_req_load) begin
        if (pend_v_q) begin
          ovf_d = 1'b1;
        end else begin
          pend_v_d   = 1'b1;
          pend_row_d = i_req_row;
        end
      end
      unique case (state_q)
        ST_IDLE: begin
          if (pend_v_q || i_req_load) begin
            row_d         = pend_v_q ? pend_row_q : i_req_row;
            // A fresh request arriving while the pending one is taken re-fills pending.
            pend_v_d      = pend_v_q && i_req_load;
            if (pend_v_q && i_req_load) pend_row_d = i_req_row;
            valid_d[wp_q] = 1'b0;
            cnt_d         = '0;
            ld_req_d      = 1'b1;
            state_d       = ST_FILL;
          end
        end
        ST_FILL: begin
          if (i_ld_valid) begin
            wr_en_c = 1'b1;
            cnt_d   = cnt_q + W_SIZE'(1);
            if (cnt_q == q_width - W_SIZE'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          valid_d[wp_q] = 1'b1;
          tag_d[wp_q]   = row_q;
          done_d        = 1'b1;
          wp_d          = (wp_q == 2'd2) ? 2'd0 : wp_q + 2'd1;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      wp_q       <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_row_q <= '0;
      valid_q    <= '0;
      ovf_q      <= 1'b0;
      ld_req_q   <= 1'b0;
      done_q     <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) tag_q[s] <= '0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      pend_v_q   <= pend_v_d;
      pend_row_q <= pend_row_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      ld_req_q   <= ld_req_d;
      done_q     <= done_d;
      tag_q      <= tag_d;
    end
  end

  // Window tap lookup: per tap, find the valid slot whose tag matches.
  row_t                 tap_row [NUM_SLOTS];
  slot_t                sel_d   [NUM_SLOTS];
  slot_t                sel_q   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] hit, pad, zero_d, zero_q;
  logic                 col_oob, miss_d, miss_q;

  always_comb begin
    miss_d  = 1'b0;
    hit     = '0;
    pad     = '0;
    zero_d  = '0;
    col_oob = (i_col >= q_width);
    for (int t = 0; t < NUM_SLOTS; t++) begin
      tap_row[t] = i_row + W_SIZE'(t) - W_SIZE'(1);
      sel_d[t]   = '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (valid_q[s] && tag_q[s] == tap_row[t]) begin
          hit[t]   = 1'b1;
          sel_d[t] = 2'(s);
        end
      end
      pad[t]    = (t == 0 && i_is_first_row) || (t == 2 && i_is_last_row);
      zero_d[t] = pad[t] || col_oob || !hit[t];
      if (!pad[t] && !col_oob && !hit[t]) miss_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      zero_q <= '1;
      miss_q <= 1'b0;
      for (int t = 0; t < NUM_SLOTS; t++) sel_q[t] <= '0;
    end else begin
      miss_q <= i_rd_en && miss_d;
      if (i_rd_en) begin
        zero_q <= zero_d;
        sel_q  <= sel_d;
      end
    end
  end

  logic [IFM_DW-1:0] rdata [NUM_SLOTS];

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_bank
    ifm_row_bank u_bank (
      .clk     (clk),
      .rstn    (rstn),
      .we_i    (wr_en_c && (wp_q == 2'(s))),
      .waddr_i (BANK_AW'(cnt_q)),
      .wdata_i (i_ld_data),
      .re_i    (i_rd_en),
      .raddr_i (BANK_AW'(i_col)),
      .rdata_o (rdata[s])
    );
  end

  assign o_ld_req       = ld_req_q;
  assign o_ld_row       = row_q;
  assign o_ld_ready     = (state_q == ST_FILL);
  assign o_buf_done     = done_q;
  assign o_busy         = (state_q != ST_IDLE) || pend_v_q;
  assign o_err_overflow = ovf_q;
  assign o_rd_miss      = miss_q;
  assign o_data0        = zero_q[0] ? '0 : rdata[sel_q[0]];
  assign o_data1        = zero_q[1] ? '0 : rdata[sel_q[1]];
  assign o_data2        = zero_q[2] ? '0 : rdata[sel_q[2]];

endmodule
